// File: rtl/master_burst_sequencer_if.sv
// Bus-side request/response handshake bundle for one burst sequencer.
// Latency: none (wires only).
// Backpressure: req_valid is held with stable fields until req_ready; rsp_valid has no backpressure.
// Ports: req_valid/req_ready/req_write/req_slave/req_addr/req_wdata (request channel),
//        rsp_valid/rsp_rdata (response channel).
interface master_burst_sequencer_if #(
    parameter int SLAVE_LEN = 2,
    parameter int ADDR_LEN  = 12,
    parameter int DATA_LEN  = 8
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [SLAVE_LEN-1:0] req_slave;
    logic [ADDR_LEN:0]    req_addr;
    logic [DATA_LEN-1:0]  req_wdata;
    logic                 rsp_valid;
    logic [DATA_LEN-1:0]  rsp_rdata;

    // The sequencer drives requests and consumes responses.
    modport master (
        output req_valid, req_write, req_slave, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    // The bus side accepts requests and produces responses.
    modport slave (
        input  req_valid, req_write, req_slave, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/master_burst_sequencer.sv
// Expands a read/write request edge into a burst of single-beat bus transactions.
// Latency: first req_valid 1 cycle after the request edge; at least 2 cycles per beat.
// Backpressure: request fields held stable while req_ready is low; no timeout while waiting for ready.
// Ports: clk, reset (sync, active-high); read/write request levels; slave/address/data/burst_num
//        configuration; bus (request/response interface, master side); busy/done/error status,
//        beat_count and rdata_last for display.
module master_burst_sequencer #(
    parameter int SLAVE_LEN = 2,
    parameter int ADDR_LEN  = 12,
    parameter int DATA_LEN  = 8,
    parameter int BURST_LEN = 12,
    parameter int TIMEOUT   = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read,
    input  logic                  write,
    input  logic [SLAVE_LEN-1:0]  slave,
    input  logic [ADDR_LEN:0]     address,
    input  logic [DATA_LEN-1:0]   data,
    input  logic [BURST_LEN:0]    burst_num,
    master_burst_sequencer_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [BURST_LEN:0]    beat_count,
    output logic [DATA_LEN-1:0]   rdata_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RSP,
        S_DONE
    } state_t;

    // Timeout fires on the cycle the counter holds TIMEOUT-1, i.e. the TIMEOUT-th waiting cycle.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t               state_q, state_d;
    logic                 read_prev_q, write_prev_q;
    logic                 op_wr_q, op_wr_d;
    logic [SLAVE_LEN-1:0] slave_q, slave_d;
    logic [ADDR_LEN-1:0]  addr_q, addr_d;
    logic [DATA_LEN-1:0]  data_q, data_d;
    logic [BURST_LEN:0]   eff_q, eff_d;
    logic [BURST_LEN:0]   beat_q, beat_d;
    logic [15:0]          tmo_q, tmo_d;
    logic                 err_q, err_d;
    logic [DATA_LEN-1:0]  rdl_q, rdl_d;

    logic                 start_rd, start_wr;
    logic [BURST_LEN:0]   beat_inc;

    // The address MSB is carried on the port but the start address wraps inside ADDR_LEN bits.
    logic unused_addr_msb;
    assign unused_addr_msb = address[ADDR_LEN];

    assign start_rd = read & ~read_prev_q;
    assign start_wr = write & ~write_prev_q;
    assign beat_inc = beat_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        op_wr_d       = op_wr_q;
        slave_d       = slave_q;
        addr_d        = addr_q;
        data_d        = data_q;
        eff_d         = eff_q;
        beat_d        = beat_q;
        tmo_d         = tmo_q;
        err_d         = err_q;
        rdl_d         = rdl_q;
        busy          = 1'b0;
        done          = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_slave = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        case (state_q)
            S_IDLE: begin
                if (start_rd || start_wr) begin
                    slave_d = slave;
                    addr_d  = address[ADDR_LEN-1:0];
                    data_d  = data;
                    eff_d   = (burst_num == '0) ? (BURST_LEN+1)'(1) : burst_num;
                    // Coincident edges resolve to a read.
                    op_wr_d = start_wr & ~start_rd;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                busy          = 1'b1;
                bus.req_valid = 1'b1;
                bus.req_write = op_wr_q;
                bus.req_slave = slave_q;
                bus.req_addr  = {1'b0, addr_q + ADDR_LEN'(beat_q)};
                bus.req_wdata = op_wr_q ? (data_q + DATA_LEN'(beat_q)) : '0;
                if (bus.req_ready) begin
                    tmo_d   = '0;
                    state_d = S_WAIT_RSP;
                end
            end

            S_WAIT_RSP: begin
                busy  = 1'b1;
                tmo_d = tmo_q + 16'd1;
                // A response arriving on the last allowed cycle still counts.
                if (bus.rsp_valid) begin
                    beat_d = beat_inc;
                    if (!op_wr_q) begin
                        rdl_d = bus.rsp_rdata;
                    end
                    state_d = (beat_inc == eff_q) ? S_DONE : S_ISSUE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            // Prev registers start high so a level held through reset release is not an edge.
            read_prev_q  <= 1'b1;
            write_prev_q <= 1'b1;
            op_wr_q      <= 1'b0;
            slave_q      <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            eff_q        <= '0;
            beat_q       <= '0;
            tmo_q        <= '0;
            err_q        <= 1'b0;
            rdl_q        <= '0;
        end else begin
            state_q      <= state_d;
            read_prev_q  <= read;
            write_prev_q <= write;
            op_wr_q      <= op_wr_d;
            slave_q      <= slave_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            eff_q        <= eff_d;
            beat_q       <= beat_d;
            tmo_q        <= tmo_d;
            err_q        <= err_d;
            rdl_q        <= rdl_d;
        end
    end

    assign error      = err_q;
    assign beat_count = beat_q;
    assign rdata_last = rdl_q;

endmodule

// File: tb/tb_master_burst_sequencer.sv
// Randomised and directed stimulus for master_burst_sequencer with a queue-based scoreboard.
// Latency: n/a.
// Backpressure: the bus responder inserts per-beat ready stalls and response delays from a plan.
module tb_master_burst_sequencer;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset, read, write;
    logic [1:0]  slave;
    logic [12:0] address;
    logic [7:0]  data;
    logic [12:0] burst_num;
    logic        busy, done, error;
    logic [12:0] beat_count;
    logic [7:0]  rdata_last;

    master_burst_sequencer_if #(.SLAVE_LEN(2), .ADDR_LEN(12), .DATA_LEN(8)) bus();

    master_burst_sequencer #(
        .SLAVE_LEN(2), .ADDR_LEN(12), .DATA_LEN(8), .BURST_LEN(12), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .read(read), .write(write),
        .slave(slave), .address(address), .data(data), .burst_num(burst_num),
        .bus(bus),
        .busy(busy), .done(done), .error(error),
        .beat_count(beat_count), .rdata_last(rdata_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [1:0]  sl;
        logic [12:0] ad;
        logic [7:0]  wd;
    } req_t;

    typedef struct packed {
        logic [12:0] bc;
        logic        err;
        logic [7:0]  rdl;
    } stat_t;

    req_t       exp_req_q[$];
    stat_t      exp_done_q[$];
    int         rsp_rdy_q[$];
    int         rsp_dly_q[$];
    logic [7:0] rsp_dat_q[$];
    int         plan_rdy[$];
    int         plan_dly[$];
    logic [7:0] plan_dat[$];

    int   n_chk = 0;
    int   n_pass = 0;
    int   hs_cnt = 0;
    int   cyc = 0;
    int   last_hs_cyc = 0;
    bit   mon_en = 1'b0;
    bit   resp_busy = 1'b0;
    logic [7:0] mdl_rdl;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Bus responder: serves one planned beat per request.
    initial begin : responder
        int rd, sd;
        logic [7:0] rv;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = 8'h00;
        @(negedge clk);
        forever begin
            if (bus.req_valid === 1'b1 && rsp_rdy_q.size() > 0) begin
                resp_busy = 1'b1;
                rd = rsp_rdy_q.pop_front();
                sd = rsp_dly_q.pop_front();
                rv = rsp_dat_q.pop_front();
                repeat (rd) @(negedge clk);
                bus.req_ready = 1'b1;
                @(negedge clk);
                bus.req_ready = 1'b0;
                if (sd < TMO) begin
                    repeat (sd) @(negedge clk);
                    bus.rsp_valid = 1'b1;
                    bus.rsp_rdata = rv;
                    @(negedge clk);
                    bus.rsp_valid = 1'b0;
                    bus.rsp_rdata = 8'($urandom);
                end
                resp_busy = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a handshake or a done pulse.
    initial begin : monitor
        req_t  cur, prev_req, e;
        stat_t s;
        bit prev_stall = 1'b0, prev_hs = 1'b0, prev_done = 1'b0;
        prev_req = '0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (mon_en) begin
                cur = {bus.req_write, bus.req_slave, bus.req_addr, bus.req_wdata};
                if (prev_stall) begin
                    check("stall_valid_held", bus.req_valid, 1);
                    check("stall_fields_stable", cur, prev_req);
                end
                if (prev_hs)   check("valid_drop_after_hs", bus.req_valid, 0);
                if (prev_done) check("done_one_cycle", done, 0);
                if (bus.req_valid && bus.req_ready) begin
                    hs_cnt++;
                    last_hs_cyc = cyc;
                    check("req_expected", exp_req_q.size() > 0, 1);
                    if (exp_req_q.size() > 0) begin
                        e = exp_req_q.pop_front();
                        check("req_fields", cur, e);
                    end
                end
                if (done) begin
                    check("done_busy_low", busy, 0);
                    check("done_expected", exp_done_q.size() > 0, 1);
                    if (exp_done_q.size() > 0) begin
                        s = exp_done_q.pop_front();
                        check("beat_count", beat_count, s.bc);
                        check("error", error, s.err);
                        check("rdata_last", rdata_last, s.rdl);
                        if (s.err) check("timeout_latency", cyc - last_hs_cyc, TMO + 1);
                    end
                end
                prev_stall = bus.req_valid && !bus.req_ready;
                prev_hs    = bus.req_valid && bus.req_ready;
                prev_done  = done;
                prev_req   = cur;
            end
        end
    end

    // Reference model of one command from the plan, then drive the request and wait for completion.
    task automatic run_cmd(input bit do_rd, input bit do_wr, input logic [1:0] sl,
                           input logic [12:0] ad, input logic [7:0] dt,
                           input logic [12:0] bn, input bit extra_edge);
        int    eff, bc;
        bit    is_wr, err, ok;
        req_t  r;
        stat_t s;
        eff   = (bn == 0) ? 1 : int'(bn);
        is_wr = do_wr && !do_rd;
        err   = 1'b0;
        bc    = 0;
        for (int b = 0; b < eff; b++) begin
            r.wr = is_wr;
            r.sl = sl;
            r.ad = {1'b0, 12'((int'(ad[11:0]) + b) % 4096)};
            r.wd = is_wr ? 8'((int'(dt) + b) % 256) : 8'h00;
            exp_req_q.push_back(r);
            rsp_rdy_q.push_back(plan_rdy[b]);
            rsp_dly_q.push_back(plan_dly[b]);
            rsp_dat_q.push_back(plan_dat[b]);
            if (plan_dly[b] >= TMO) begin
                err = 1'b1;
                break;
            end
            bc++;
            if (!is_wr) mdl_rdl = plan_dat[b];
        end
        s.bc  = 13'(bc);
        s.err = err;
        s.rdl = mdl_rdl;
        exp_done_q.push_back(s);
        plan_rdy.delete();
        plan_dly.delete();
        plan_dat.delete();

        @(negedge clk);
        slave = sl; address = ad; data = dt; burst_num = bn;
        read = do_rd; write = do_wr;
        @(negedge clk);
        #1;
        check("first_req_latency", bus.req_valid, 1);
        check("busy_after_start", busy, 1);
        // Configuration changes mid-sequence must not matter.
        read = 1'b0; write = 1'b0;
        slave = 2'($urandom); address = 13'($urandom); data = 8'($urandom); burst_num = 13'($urandom);
        if (extra_edge) begin
            @(negedge clk);
            check("busy_before_extra_edge", busy, 1);
            write = 1'b1;
            @(negedge clk);
            write = 1'b0;
        end
        ok = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            #2;
            if (exp_done_q.size() == 0 && !busy && !done && rsp_rdy_q.size() == 0 && !resp_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("sequence_completes", ok, 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int base, sel, bn, eff;
        bit ok, rd, wr;
        req_t r;
        mdl_rdl = 8'h00;
        reset = 1'b1; read = 1'b0; write = 1'b0;
        slave = '0; address = '0; data = '0; burst_num = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_valid", bus.req_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_beat_count", beat_count, 0);
        check("rst_rdata_last", rdata_last, 0);
        check("rst_req_addr", bus.req_addr, 0);
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Single write beat.
        plan_rdy = '{0}; plan_dly = '{2}; plan_dat = '{8'h00};
        run_cmd(0, 1, 2'd2, 13'h010, 8'h5A, 13'd1, 0);

        // Read burst wrapping the 12-bit address.
        plan_rdy = '{0, 1, 0, 2}; plan_dly = '{1, 0, 3, 1};
        plan_dat = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_cmd(1, 0, 2'd1, 13'h0FFE, 8'h00, 13'd4, 0);

        // 3-beat write with a 5-cycle stall on beat 2 and an ignored write edge while busy.
        plan_rdy = '{0, 5, 0}; plan_dly = '{1, 1, 1}; plan_dat = '{8'h00, 8'h00, 8'h00};
        run_cmd(0, 1, 2'd3, 13'h0200, 8'hFE, 13'd3, 1);

        // Timeout on beat 1 of 3.
        plan_rdy = '{0}; plan_dly = '{255}; plan_dat = '{8'h00};
        run_cmd(1, 0, 2'd0, 13'h0040, 8'h00, 13'd3, 0);

        // Next command clears error; response on the last allowed waiting cycle.
        plan_rdy = '{1, 0}; plan_dly = '{TMO - 1, 0}; plan_dat = '{8'hA5, 8'h3C};
        run_cmd(1, 0, 2'd1, 13'h1123, 8'h00, 13'd2, 0);

        // Coincident read and write edges give a read.
        plan_rdy = '{0, 0}; plan_dly = '{0, 0}; plan_dat = '{8'h77, 8'h88};
        run_cmd(1, 1, 2'd2, 13'h0555, 8'h99, 13'd2, 0);

        // Burst count 0 gives one beat.
        plan_rdy = '{0}; plan_dly = '{0}; plan_dat = '{8'h00};
        run_cmd(0, 1, 2'd0, 13'h0ABC, 8'h10, 13'd0, 0);

        // Write held through reset release must not start a sequence.
        @(negedge clk);
        write = 1'b1; reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mdl_rdl = 8'h00;
        repeat (4) begin
            @(negedge clk);
            #1;
            check("held_write_no_busy", busy, 0);
            check("held_write_no_req", bus.req_valid, 0);
        end
        write = 1'b0;
        @(negedge clk);

        // Reset during beat 2 of a 5-beat write.
        base = hs_cnt;
        for (int b = 0; b < 2; b++) begin
            r.wr = 1'b1; r.sl = 2'd1; r.ad = 13'(16'h0100 + b); r.wd = 8'(8'h30 + b);
            exp_req_q.push_back(r);
        end
        rsp_rdy_q.push_back(0); rsp_dly_q.push_back(1); rsp_dat_q.push_back(8'h00);
        rsp_rdy_q.push_back(0); rsp_dly_q.push_back(5); rsp_dat_q.push_back(8'h00);
        @(negedge clk);
        slave = 2'd1; address = 13'h0100; data = 8'h30; burst_num = 13'd5; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            #2;
            if (hs_cnt >= base + 2) begin
                ok = 1'b1;
                break;
            end
        end
        check("reset_test_reached_beat2", ok, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        mdl_rdl = 8'h00;
        check("midrst_req_valid", bus.req_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_beat_count", beat_count, 0);
        check("midrst_done", done, 0);
        check("midrst_error", error, 0);
        repeat (12) @(negedge clk);
        check("midrst_responder_drained", rsp_rdy_q.size(), 0);

        // Randomised commands.
        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 2);
            rd  = (sel != 1);
            wr  = (sel != 0);
            bn  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 5);
            eff = (bn == 0) ? 1 : bn;
            for (int b = 0; b < eff; b++) begin
                plan_rdy.push_back($urandom_range(0, 3));
                plan_dly.push_back(($urandom_range(0, 15) == 0) ? 255 : $urandom_range(0, TMO - 1));
                plan_dat.push_back(8'($urandom));
            end
            run_cmd(rd, wr, 2'($urandom), 13'($urandom), 8'($urandom), 13'(bn), 0);
        end

        repeat (3) @(negedge clk);
        check("exp_req_drained", exp_req_q.size(), 0);
        check("exp_done_drained", exp_done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
